// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the execute-stage forwarding/hazard scheduler:
// forward-mux select codes, RV32 major opcodes and the history-slot record.
package hazard_ctrl_pkg;

    // Forward-mux select encodings driven to the EX operand muxes
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_ONE  = 2'b01;
    localparam logic [1:0] FWD_TWO  = 2'b10;

    // RV32 major opcodes recognised by the decoder
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_CSR    = 7'b1110011;

    // One pipeline history entry: is it live, does it write a register, which one
    typedef struct packed {
        logic       valid;
        logic       writes_rd;
        logic [4:0] rd;
    } hist_slot_t;

endpackage

// File: rtl/hazard_decode.sv
// Register-usage decoder: classifies an instruction by which source
// registers it reads and whether it writes a (non-x0) destination.
module hazard_decode
    import hazard_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] instruction,
    output logic            uses_rs1,
    output logic            uses_rs2,
    output logic            writes_rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_upper_bits;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign rd     = instruction[11:7];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];

    // funct7 / immediate high bits never affect register usage
    assign unused_upper_bits = ^instruction[XLEN-1:25];

    // Classify operand reads and destination write from the major opcode
    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OPC_OP: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                writes_rd = 1'b1;
            end
            OPC_CSR: begin
                // Immediate CSR forms carry a zimm in the rs1 field
                uses_rs1  = ~funct3[2];
                writes_rd = 1'b1;
            end
            default: ;
        endcase
        // x0 is hardwired zero: writing it never creates a dependency
        if (rd == 5'd0) begin
            writes_rd = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Execute-stage forwarding/hazard scheduler. Tracks destination registers of
// the EX, WB and post-WB (OLD) instructions and registers the A/B forward-mux
// selects for the instruction entering EX. Stall freezes all history; a flush
// seen during a stall is remembered and turns the next advancing slot into a bubble.
// Optional feature macro: HAZARD_CTRL_PERF_EN adds saturating forward counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  id_instruction,
    input  logic             id_valid,
    input  logic             stall,
    input  logic             flush,
    output logic [1:0]       a_forward_select,
    output logic [1:0]       b_forward_select,
    output logic             ex_valid,
    output logic             wb_reg_en
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] fwd1_count,
    output logic [CNT_W-1:0] fwd2_count
`endif
);

    logic       dec_uses_rs1;
    logic       dec_uses_rs2;
    logic       dec_writes_rd;
    logic [4:0] dec_rs1;
    logic [4:0] dec_rs2;
    logic [4:0] dec_rd;

    logic       vld_p0;
    logic       flush_pend;
    logic [1:0] a_sel_p0;
    logic [1:0] b_sel_p0;
    hist_slot_t slot_p0;
    hist_slot_t hist_p1;   // EX
    hist_slot_t hist_p2;   // WB
    hist_slot_t hist_p3;   // OLD
    logic       unused_old_slot;

    // Newest live writer of src wins; x0 or an unused operand never forwards
    function automatic logic [1:0] pick_fwd(input logic       used,
                                            input logic [4:0] src,
                                            input hist_slot_t newer,
                                            input hist_slot_t older);
        if (!used || src == 5'd0) begin
            return FWD_NONE;
        end
        if (newer.valid && newer.writes_rd && newer.rd == src) begin
            return FWD_ONE;
        end
        if (older.valid && older.writes_rd && older.rd == src) begin
            return FWD_TWO;
        end
        return FWD_NONE;
    endfunction

    hazard_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instruction (id_instruction),
        .uses_rs1    (dec_uses_rs1),
        .uses_rs2    (dec_uses_rs2),
        .writes_rd   (dec_writes_rd),
        .rs1         (dec_rs1),
        .rs2         (dec_rs2),
        .rd          (dec_rd)
    );

    // ---- p0: incoming instruction (decode stage), selects computed here ----
    assign vld_p0   = id_valid & ~flush & ~flush_pend;
    assign a_sel_p0 = vld_p0 ? pick_fwd(dec_uses_rs1, dec_rs1, hist_p1, hist_p2) : FWD_NONE;
    assign b_sel_p0 = vld_p0 ? pick_fwd(dec_uses_rs2, dec_rs2, hist_p1, hist_p2) : FWD_NONE;
    assign slot_p0  = '{valid:     vld_p0,
                        writes_rd: vld_p0 & dec_writes_rd,
                        rd:        vld_p0 ? dec_rd : 5'd0};

    // Datapath old-writeback register must freeze together with the history
    assign wb_reg_en = ~stall;

    // ---- p1..p3: history shift and registered selects on each advance edge ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_p1          <= '0;
            hist_p2          <= '0;
            hist_p3          <= '0;
            a_forward_select <= FWD_NONE;
            b_forward_select <= FWD_NONE;
            flush_pend       <= 1'b0;
        end else if (!stall) begin
            hist_p3          <= hist_p2;
            hist_p2          <= hist_p1;
            hist_p1          <= slot_p0;
            a_forward_select <= a_sel_p0;
            b_forward_select <= b_sel_p0;
            flush_pend       <= 1'b0;
        end else if (flush) begin
            flush_pend       <= 1'b1;
        end
    end

    assign ex_valid = hist_p1.valid;

    // OLD mirrors the external old-writeback register; nothing here forwards from it
    assign unused_old_slot = ^hist_p3;

`ifdef HAZARD_CTRL_PERF_EN
    logic [1:0] fwd1_inc;
    logic [1:0] fwd2_inc;

    // Add 0..2 to a counter, clamping at all-ones
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    assign fwd1_inc = {1'b0, a_sel_p0 == FWD_ONE} + {1'b0, b_sel_p0 == FWD_ONE};
    assign fwd2_inc = {1'b0, a_sel_p0 == FWD_TWO} + {1'b0, b_sel_p0 == FWD_TWO};

    // Count forwards issued with each advancing instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd1_count <= '0;
            fwd2_count <= '0;
        end else if (!stall) begin
            fwd1_count <= sat_add(fwd1_count, fwd1_inc);
            fwd2_count <= sat_add(fwd2_count, fwd2_inc);
        end
    end
`else
    // Performance counters not built
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed forwarding scenarios plus a
// randomized run compared against a list-of-producers reference model.
module tb_hazard_ctrl;

    localparam logic [6:0] T_OP   = 7'h33;
    localparam logic [6:0] T_IMM  = 7'h13;
    localparam logic [6:0] T_LD   = 7'h03;
    localparam logic [6:0] T_ST   = 7'h23;
    localparam logic [6:0] T_BR   = 7'h63;
    localparam logic [6:0] T_JALR = 7'h67;
    localparam logic [6:0] T_JAL  = 7'h6f;
    localparam logic [6:0] T_LUI  = 7'h37;
    localparam logic [6:0] T_AUI  = 7'h17;
    localparam logic [6:0] T_SYS  = 7'h73;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] id_instruction = '0;
    logic        id_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  a_forward_select;
    logic [1:0]  b_forward_select;
    logic        ex_valid;
    logic        wb_reg_en;
`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] fwd1_count;
    logic [31:0] fwd2_count;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: destination of the last two issued slots (0 = none), newest last
    int         prod[$];
    bit         pend;
    logic [1:0] exp_a, exp_b;
    logic       exp_ev;
    int         exp_f1, exp_f2;

    hazard_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_instruction   (id_instruction),
        .id_valid         (id_valid),
        .stall            (stall),
        .flush            (flush),
        .a_forward_select (a_forward_select),
        .b_forward_select (b_forward_select),
        .ex_valid         (ex_valid),
        .wb_reg_en        (wb_reg_en)
`ifdef HAZARD_CTRL_PERF_EN
        ,
        .fwd1_count       (fwd1_count),
        .fwd2_count       (fwd2_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mk(logic [6:0] opc, int rd, int f3, int rs1, int rs2);
        logic [4:0] r_d, r_1, r_2;
        logic [2:0] f;
        r_d = rd[4:0]; r_1 = rs1[4:0]; r_2 = rs2[4:0]; f = f3[2:0];
        return {7'b0, r_2, r_1, f, r_d, opc};
    endfunction

    function automatic bit m_writes(logic [31:0] i);
        if (i[11:7] == 5'd0) return 1'b0;
        return i[6:0] inside {T_OP, T_IMM, T_LD, T_LUI, T_AUI, T_JAL, T_JALR, T_SYS};
    endfunction

    function automatic bit m_uses1(logic [31:0] i);
        if (i[6:0] == T_SYS) return !i[14];
        return i[6:0] inside {T_OP, T_IMM, T_LD, T_ST, T_BR, T_JALR};
    endfunction

    function automatic bit m_uses2(logic [31:0] i);
        return i[6:0] inside {T_OP, T_ST, T_BR};
    endfunction

    function automatic logic [1:0] m_sel(bit used, int src);
        if (!used || src == 0) return 2'd0;
        if (src == prod[1]) return 2'd1;
        if (src == prod[0]) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        prod = {0, 0};
        pend = 1'b0;
        exp_a = 2'd0; exp_b = 2'd0; exp_ev = 1'b0;
        exp_f1 = 0; exp_f2 = 0;
    endtask

    task automatic model_step(logic [31:0] ins, bit v, bit st, bit fl);
        bit live;
        if (st) begin
            if (fl) pend = 1'b1;
        end else begin
            live   = v && !fl && !pend;
            pend   = 1'b0;
            exp_a  = live ? m_sel(m_uses1(ins), int'(ins[19:15])) : 2'd0;
            exp_b  = live ? m_sel(m_uses2(ins), int'(ins[24:20])) : 2'd0;
            exp_ev = live;
            exp_f1 += int'(exp_a == 2'd1) + int'(exp_b == 2'd1);
            exp_f2 += int'(exp_a == 2'd2) + int'(exp_b == 2'd2);
            prod.push_back((live && m_writes(ins)) ? int'(ins[11:7]) : 0);
            void'(prod.pop_front());
        end
    endtask

    // Apply one cycle of inputs; returns 1 time unit after the rising edge
    task automatic step(logic [31:0] ins, bit v, bit st, bit fl);
        id_instruction = ins; id_valid = v; stall = st; flush = fl;
        model_step(ins, v, st, fl);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        id_instruction = '0; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({a_forward_select, b_forward_select, ex_valid} !== 5'b00_00_0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 00000", {a_forward_select, b_forward_select, ex_valid});
        end
        do_reset();
    endtask

    task automatic test_forwarding();
        do_reset();
        // back-to-back dependency
        step(mk(T_OP, 5, 0, 1, 2), 1, 0, 0);
        step(mk(T_OP, 6, 0, 5, 3), 1, 0, 0);
        n_vec++;
        if ({a_forward_select, b_forward_select, ex_valid} !== 5'b01_00_1) begin
            n_bad++;
            $display("FAIL fwd_one: got %b want 01001", {a_forward_select, b_forward_select, ex_valid});
        end
        // gap of one bubble gives a two-cycle forward
        step(mk(T_OP, 5, 0, 1, 2), 1, 0, 0);
        step(32'd0, 0, 0, 0);
        n_vec++;
        if (ex_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL nop_bubble: got ex_valid=%b want 0", ex_valid);
        end
        step(mk(T_OP, 7, 0, 4, 5), 1, 0, 0);
        n_vec++;
        if ({a_forward_select, b_forward_select, ex_valid} !== 5'b00_10_1) begin
            n_bad++;
            $display("FAIL fwd_two: got %b want 00101", {a_forward_select, b_forward_select, ex_valid});
        end
        // addi x5 / lw x5 / sw x5,0(x5): newest producer wins
        step(mk(T_IMM, 5, 0, 1, 0), 1, 0, 0);
        step(mk(T_LD, 5, 2, 1, 0), 1, 0, 0);
        n_vec++;
        if ({a_forward_select, b_forward_select, ex_valid} !== 5'b00_00_1) begin
            n_bad++;
            $display("FAIL lw_independent: got %b want 00001", {a_forward_select, b_forward_select, ex_valid});
        end
        step(mk(T_ST, 0, 2, 5, 5), 1, 0, 0);
        n_vec++;
        if ({a_forward_select, b_forward_select, ex_valid} !== 5'b01_01_1) begin
            n_bad++;
            $display("FAIL sw_newest: got %b want 01011", {a_forward_select, b_forward_select, ex_valid});
        end
`ifdef HAZARD_CTRL_PERF_EN
        n_vec++;
        if (fwd1_count !== 32'd3 || fwd2_count !== 32'd1) begin
            n_bad++;
            $display("FAIL perf_counts: got fwd1=%0d fwd2=%0d want fwd1=3 fwd2=1", fwd1_count, fwd2_count);
        end
`endif
        // store writes nothing: lw in WB still beats addi in OLD
        step(mk(T_OP, 8, 0, 5, 1), 1, 0, 0);
        n_vec++;
        if ({a_forward_select, b_forward_select, ex_valid} !== 5'b10_00_1) begin
            n_bad++;
            $display("FAIL lw_over_addi: got %b want 10001", {a_forward_select, b_forward_select, ex_valid});
        end
    endtask

    task automatic test_x0_csr();
        step(mk(T_OP, 0, 0, 1, 2), 1, 0, 0);
        step(mk(T_OP, 3, 0, 0, 0), 1, 0, 0);
        n_vec++;
        if ({a_forward_select, b_forward_select, ex_valid} !== 5'b00_00_1) begin
            n_bad++;
            $display("FAIL x0_source: got %b want 00001", {a_forward_select, b_forward_select, ex_valid});
        end
        step(mk(T_IMM, 9, 0, 0, 0), 1, 0, 0);
        step(mk(T_SYS, 10, 5, 9, 0), 1, 0, 0);
        n_vec++;
        if ({a_forward_select, b_forward_select, ex_valid} !== 5'b00_00_1) begin
            n_bad++;
            $display("FAIL csrrwi_zimm: got %b want 00001", {a_forward_select, b_forward_select, ex_valid});
        end
        step(mk(T_IMM, 9, 0, 0, 0), 1, 0, 0);
        step(mk(T_SYS, 11, 1, 9, 0), 1, 0, 0);
        n_vec++;
        if ({a_forward_select, b_forward_select, ex_valid} !== 5'b01_00_1) begin
            n_bad++;
            $display("FAIL csrrw_rs1: got %b want 01001", {a_forward_select, b_forward_select, ex_valid});
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(mk(T_OP, 5, 0, 1, 2), 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(mk(T_OP, 6, 0, 5, 3), 1, 1, 0);
            n_vec++;
            if ({a_forward_select, b_forward_select, ex_valid, wb_reg_en} !== 6'b00_00_1_0) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got %b want 000010", i,
                         {a_forward_select, b_forward_select, ex_valid, wb_reg_en});
            end
        end
        step(mk(T_OP, 6, 0, 5, 3), 1, 0, 0);
        n_vec++;
        if ({a_forward_select, b_forward_select, ex_valid, wb_reg_en} !== 6'b01_00_1_1) begin
            n_bad++;
            $display("FAIL stall_release: got %b want 010011",
                     {a_forward_select, b_forward_select, ex_valid, wb_reg_en});
        end
    endtask

    task automatic test_flush();
        do_reset();
        step(mk(T_OP, 5, 0, 1, 2), 1, 0, 0);
        step(mk(T_OP, 6, 0, 5, 3), 1, 1, 1);
        n_vec++;
        if ({a_forward_select, b_forward_select, ex_valid} !== 5'b00_00_1) begin
            n_bad++;
            $display("FAIL flush_stalled_hold: got %b want 00001", {a_forward_select, b_forward_select, ex_valid});
        end
        step(mk(T_OP, 6, 0, 5, 3), 1, 0, 0);
        n_vec++;
        if ({a_forward_select, b_forward_select, ex_valid} !== 5'b00_00_0) begin
            n_bad++;
            $display("FAIL flush_pend_bubble: got %b want 00000", {a_forward_select, b_forward_select, ex_valid});
        end
        step(mk(T_OP, 7, 0, 5, 1), 1, 0, 0);
        n_vec++;
        if ({a_forward_select, b_forward_select, ex_valid} !== 5'b10_00_1) begin
            n_bad++;
            $display("FAIL flush_single_bubble: got %b want 10001", {a_forward_select, b_forward_select, ex_valid});
        end
        step(mk(T_OP, 8, 0, 7, 7), 1, 0, 1);
        n_vec++;
        if ({a_forward_select, b_forward_select, ex_valid} !== 5'b00_00_0) begin
            n_bad++;
            $display("FAIL flush_direct: got %b want 00000", {a_forward_select, b_forward_select, ex_valid});
        end
        // asynchronous reset in the middle of a dependent stream
        step(mk(T_OP, 5, 0, 1, 2), 1, 0, 0);
        step(mk(T_OP, 5, 0, 5, 5), 1, 0, 0);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({a_forward_select, b_forward_select, ex_valid} !== 5'b00_00_0) begin
            n_bad++;
            $display("FAIL async_reset: got %b want 00000", {a_forward_select, b_forward_select, ex_valid});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(T_OP, 6, 0, 5, 5), 1, 0, 0);
        n_vec++;
        if ({a_forward_select, b_forward_select, ex_valid} !== 5'b00_00_1) begin
            n_bad++;
            $display("FAIL post_reset_first: got %b want 00001", {a_forward_select, b_forward_select, ex_valid});
        end
    endtask

    task automatic test_random();
        logic [6:0] opcs [11];
        logic [31:0] ins;
        bit v, st, fl;
        opcs = '{T_OP, T_IMM, T_LD, T_ST, T_BR, T_JALR, T_JAL, T_LUI, T_AUI, T_SYS, 7'h7f};
        do_reset();
        for (int i = 0; i < 500; i++) begin
            ins = mk(opcs[$urandom_range(0, 10)], $urandom_range(0, 3), $urandom_range(0, 7),
                     $urandom_range(0, 3), $urandom_range(0, 3));
            v  = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 5) == 0);
            step(ins, v, st, fl);
            n_vec++;
            if ({a_forward_select, b_forward_select, ex_valid, wb_reg_en} !== {exp_a, exp_b, exp_ev, !st}) begin
                n_bad++;
                $display("FAIL random[%0d]: got %b want %b (ins=%h v=%0d st=%0d fl=%0d)", i,
                         {a_forward_select, b_forward_select, ex_valid, wb_reg_en},
                         {exp_a, exp_b, exp_ev, !st}, ins, v, st, fl);
            end
        end
`ifdef HAZARD_CTRL_PERF_EN
        n_vec++;
        if (fwd1_count !== 32'(exp_f1) || fwd2_count !== 32'(exp_f2)) begin
            n_bad++;
            $display("FAIL random_perf: got fwd1=%0d fwd2=%0d want fwd1=%0d fwd2=%0d",
                     fwd1_count, fwd2_count, exp_f1, exp_f2);
        end
`endif
    endtask

    initial begin
        model_reset();
        test_reset();
        test_forwarding();
        test_x0_csr();
        test_stall();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
